instruction_loader: RTL and testbench

Boot-time writer for the instruction memory read by the fetch stage. Accepts a byte stream on a valid/ready handshake, assembles big-endian 32-bit instructions, and writes them to consecutive word addresses starting at 0. It holds the fetch stage stalled through `cpu_enable` until a complete, length-checked program image has been written.

---
 rtl/instruction_loader.sv | 200 ++++++++++++++++++++
 tb/tb_instruction_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Boot-time instruction memory loader: byte stream -> big-endian words at addresses 0..N-1.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | reset state, waiting for start
// LEN_HI   | expecting word count bits [15:8]
// LEN_LO   | expecting word count bits [7:0], range-checked here
// DATA     | assembling words, one memory write per 4 bytes
// CHECK    | expecting checksum byte (LOADER_CHECKSUM_EN only)
// FINISH   | one-cycle settle so DONE/ERROR trail the last write or byte
// DONE     | image loaded, fetch stage released
// ERROR    | load aborted, fetch stage held
module instruction_loader #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int MEM_DEPTH         = 256
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid,
    output logic                         byte_ready,
    output logic                         wr_en,
    output logic [PC_WIDTH-1:0]          wr_addr,
    output logic [INSTRUCTION_WIDTH-1:0] wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic                         cpu_enable
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK  = 3'd4,
`endif
        S_FINISH = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = S_CHECK;
`else
    localparam state_t AFTER_DATA = S_FINISH;
`endif

    localparam logic [16:0] DEPTH_LIMIT = 17'(MEM_DEPTH);

    state_t      state;
    state_t      next_state;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] assembly;
    logic        fail;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xor_acc;
`endif

    logic        accept;
    logic [15:0] len_full;
    logic        len_over;
    logic        last_byte;
    logic        last_word;

    assign accept    = byte_valid && byte_ready;
    assign len_full  = {len[15:8], byte_in};
    assign len_over  = {1'b0, len_full} > DEPTH_LIMIT;
    assign last_byte = (byte_cnt == 2'd3);
    assign last_word = ((word_idx + 16'd1) == len);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_over)              next_state = S_FINISH;
                    else if (len_full == 16'd0) next_state = AFTER_DATA;
                    else                        next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && last_byte && last_word) next_state = AFTER_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) next_state = S_FINISH;
            end
`endif
            S_FINISH: begin
                next_state = fail ? S_ERROR : S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_enable = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            S_FINISH: busy = 1'b1;
            S_DONE: begin
                done       = 1'b1;
                cpu_enable = 1'b1;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            assembly <= '0;
            fail     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc  <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_LEN_HI: begin
                    if (accept) len[15:8] <= byte_in;
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= byte_in;
                        byte_cnt <= '0;
                        word_idx <= '0;
                        fail     <= len_over;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= PC_WIDTH'(word_idx);
                            wr_data  <= INSTRUCTION_WIDTH'({assembly, byte_in});
                            word_idx <= word_idx + 16'd1;
                        end else begin
                            assembly <= {assembly[15:0], byte_in};
                        end
`ifdef LOADER_CHECKSUM_EN
                        xor_acc <= xor_acc ^ byte_in;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) fail <= (byte_in != xor_acc);
                end
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) xor_acc <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader; checksum steps run when
// LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_enable;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int nw      = 0;
    int base    = 0;
    logic [31:0] log_addr [16];
    logic [31:0] log_data [16];
    int          log_cyc  [16];

    instruction_loader #(
        .PC_WIDTH(32),
        .INSTRUCTION_WIDTH(32),
        .MEM_DEPTH(256)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .error(error),
        .cpu_enable(cpu_enable)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (wr_en && nw < 16) begin
            log_addr[nw] <= wr_addr;
            log_data[nw] <= wr_data;
            log_cyc[nw]  <= cyc;
            nw           <= nw + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the byte is taken.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            n_tests++;
            n_fail++;
            $error("FAIL byte_ready_timeout: observed 0 expected 1 for byte %h", b);
        end
        @(negedge clock);
    endtask

    task automatic gap(input int k);
        byte_valid = 1'b0;
        repeat (k) @(negedge clock);
    endtask

    task automatic do_start();
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        #2 reset = 1'b0;
        #5;
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_cpu_enable", cpu_enable, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // gap-free two-word load
        do_start();
        chk("start_to_ready", byte_ready, 1);
        send(8'h00); send(8'h02);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
`ifdef LOADER_CHECKSUM_EN
        send(8'h44);
`endif
        byte_valid = 1'b0;
        chk("t1_done_not_with_write", done, 0);
        chk("t1_ready_low_after_last", byte_ready, 0);
        @(negedge clock);
        chk("t1_done", done, 1);
        chk("t1_cpu_enable", cpu_enable, 1);
        chk("t1_busy", busy, 0);
        chk("t1_write_count", nw, 2);
        chk("t1_addr0", log_addr[0], 32'h0);
        chk("t1_data0", log_data[0], 32'h11223344);
        chk("t1_addr1", log_addr[1], 32'h1);
        chk("t1_data1", log_data[1], 32'hAABBCCDD);
        chk("t1_write_spacing", log_cyc[1] - log_cyc[0], 4);
        chk("t1_wr_en_low", wr_en, 0);
        chk("t1_addr_hold", wr_addr, 32'h1);
        chk("t1_data_hold", wr_data, 32'hAABBCCDD);

        // oversize length: N = MEM_DEPTH + 1
        do_start();
        chk("t2_done_cleared", done, 0);
        chk("t2_busy", busy, 1);
        base = nw;
        send(8'h01); send(8'h01);
        byte_valid = 1'b0;
        chk("t2_error_not_yet", error, 0);
        @(negedge clock);
        chk("t2_error", error, 1);
        chk("t2_cpu_enable", cpu_enable, 0);
        chk("t2_busy_low", busy, 0);
        chk("t2_ready_low", byte_ready, 0);
        @(negedge clock);
        chk("t2_no_writes", nw, base);
        do_start();
        chk("t2_error_cleared", error, 0);
        chk("t2_back_in_len_hi", byte_ready, 1);

        // same image with valid gaps and an ignored start mid-DATA
        base = nw;
        send(8'h00); gap(2); send(8'h02);
        send(8'h11); gap(1); send(8'h22);
        start = 1'b1;
        send(8'h33);
        start = 1'b0;
        gap(3); send(8'h44);
        send(8'hAA); gap(1); send(8'hBB); send(8'hCC); gap(2); send(8'hDD);
`ifdef LOADER_CHECKSUM_EN
        gap(1); send(8'h44);
`endif
        byte_valid = 1'b0;
        for (int i = 0; i < 10 && !done; i++) @(negedge clock);
        chk("t3_done", done, 1);
        @(negedge clock);
        chk("t3_write_count", nw - base, 2);
        chk("t3_addr0", log_addr[base], 32'h0);
        chk("t3_data0", log_data[base], 32'h11223344);
        chk("t3_addr1", log_addr[base+1], 32'h1);
        chk("t3_data1", log_data[base+1], 32'hAABBCCDD);

        // asynchronous reset two bytes into word 1
        do_start();
        send(8'h00); send(8'h02);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        send(8'h12); send(8'h34);
        #2 reset = 1'b0;
        #1;
        chk("t4_byte_ready", byte_ready, 0);
        chk("t4_wr_en", wr_en, 0);
        chk("t4_wr_addr", wr_addr, 0);
        chk("t4_wr_data", wr_data, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_error", error, 0);
        chk("t4_cpu_enable", cpu_enable, 0);
        byte_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        do_start();
        base = nw;
        send(8'h00); send(8'h01);
        send(8'h0B); send(8'hAD); send(8'hF0); send(8'h0D);
`ifdef LOADER_CHECKSUM_EN
        send(8'h5B);
`endif
        byte_valid = 1'b0;
        @(negedge clock);
        chk("t4_reload_done", done, 1);
        chk("t4_reload_count", nw - base, 1);
        chk("t4_reload_addr", log_addr[base], 32'h0);
        chk("t4_reload_data", log_data[base], 32'h0BADF00D);

        // empty image
        do_start();
        base = nw;
        send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        byte_valid = 1'b0;
        chk("t5_done_not_yet", done, 0);
        @(negedge clock);
        chk("t5_done", done, 1);
        chk("t5_cpu_enable", cpu_enable, 1);
        @(negedge clock);
        chk("t5_no_writes", nw, base);

`ifdef LOADER_CHECKSUM_EN
        // checksum match and mismatch
        do_start();
        send(8'h00); send(8'h01);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h04);
        byte_valid = 1'b0;
        @(negedge clock);
        chk("t6_sum_ok_done", done, 1);
        do_start();
        base = nw;
        send(8'h00); send(8'h01);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05);
        byte_valid = 1'b0;
        @(negedge clock);
        chk("t6_sum_bad_error", error, 1);
        chk("t6_sum_bad_cpu_enable", cpu_enable, 0);
        chk("t6_sum_bad_write_count", nw - base, 1);
        chk("t6_sum_bad_write_data", log_data[base], 32'h01020304);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
